// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release/auto-repeat
// strobes and an 8-bit wrapping press counter. All outputs are registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 180000,
  parameter int REPEAT_DELAY    = 18000000,
  parameter int REPEAT_PERIOD   = 3600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W    = $clog2(RPT_MAX) + 1;
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = REPEAT_EN ? RP_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic sync1, sync2, btn_s;

  state_t          state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic [RP_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic            rpt_periodic, rpt_periodic_nxt;
  logic            pressed_nxt, press_pulse_nxt, release_pulse_nxt, repeat_pulse_nxt;
  logic [7:0]      press_count_nxt;

  // Synchronizer resets to the released (pulled-up) level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign btn_s = ~sync2;

  // NOTE: every value written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt         = state;
    db_cnt_nxt        = db_cnt;
    rpt_cnt_nxt       = rpt_cnt;
    rpt_periodic_nxt  = rpt_periodic;
    pressed_nxt       = pressed;
    press_pulse_nxt   = 1'b0;
    release_pulse_nxt = 1'b0;
    repeat_pulse_nxt  = 1'b0;
    press_count_nxt   = press_count;

    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt        = PRESSED;
          pressed_nxt      = 1'b1;
          press_pulse_nxt  = 1'b1;
          press_count_nxt  = press_count + 8'd1;
          rpt_cnt_nxt      = '0;
          rpt_periodic_nxt = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = DB_W'(1);
        end else if (REPEAT_EN) begin
          // First interval is the delay, every later one the period.
          if (rpt_cnt == (rpt_periodic ? PERIOD_LAST : DELAY_LAST)) begin
            repeat_pulse_nxt = 1'b1;
            rpt_cnt_nxt      = '0;
            rpt_periodic_nxt = 1'b1;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        // Repeat counter is left untouched here, so it resumes if the release was a bounce.
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt         = RELEASED;
          pressed_nxt       = 1'b0;
          release_pulse_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      rpt_cnt       <= '0;
      rpt_periodic  <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      rpt_cnt       <= rpt_cnt_nxt;
      rpt_periodic  <= rpt_periodic_nxt;
      pressed       <= pressed_nxt;
      press_pulse   <= press_pulse_nxt;
      release_pulse <= release_pulse_nxt;
      repeat_pulse  <= repeat_pulse_nxt;
      press_count   <= press_count_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
// stimulus queues expected strobes with their cycle numbers; a negedge monitor pops and compares.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  typedef enum logic [2:0] {
    K_PRESS = 3'b001,
    K_REL   = 3'b010,
    K_RPT   = 3'b100
  } kind_e;

  typedef struct {
    kind_e      kind;
    int         cyc;
    logic [7:0] count;
    logic       pressed;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_n = 1'b1;
  logic       pressed, press_pulse, release_pulse, repeat_pulse;
  logic [7:0] press_count;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  sb_entry_t sb[$];
  sb_entry_t exp_e;
  logic [2:0] pulses;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  // Edge number: the value of cyc seen at a negedge is the number of the preceding posedge.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push(input kind_e k, input int c, input int cnt, input logic p);
    sb_entry_t e;
    e.kind    = k;
    e.cyc     = c;
    e.count   = 8'(cnt);
    e.pressed = p;
    sb.push_back(e);
  endtask

  // Short press (no repeat) followed by a clean release; called at a negedge.
  task automatic clean_press(input int cnt);
    int t;
    t = cyc + 1;
    btn_n = 1'b0;
    push(K_PRESS, t + DB + 1, cnt, 1'b1);
    wait_cyc(t + 6);
    btn_n = 1'b1;
    push(K_REL, t + 12, cnt, 1'b0);
    wait_cyc(t + 12);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    pulses = {repeat_pulse, release_pulse, press_pulse};
    if (pulses != 3'b000) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", int'(pulses), 0);
      end else begin
        exp_e = sb.pop_front();
        check("strobe_kind", int'(pulses), int'(exp_e.kind));
        check("strobe_cycle", cyc, exp_e.cyc);
        check("strobe_count", int'(press_count), int'(exp_e.count));
        check("strobe_pressed", int'(pressed), int'(exp_e.pressed));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pressed", int'(pressed), 0);
    check("rst_count", int'(press_count), 0);
    check("rst_pulses", int'({repeat_pulse, release_pulse, press_pulse}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Bounce: three low samples are one short of acceptance.
    t = cyc + 1;
    btn_n = 1'b0;
    wait_cyc(t + 2);
    btn_n = 1'b1;
    wait_cyc(t + 10);
    check("bounce_pressed", int'(pressed), 0);
    check("bounce_count", int'(press_count), 0);

    // Press and hold: repeats at +8, +11, +14, +17, +20 after press_pulse.
    t = cyc + 1;
    btn_n = 1'b0;
    push(K_PRESS, t + 5, 1, 1'b1);
    for (int i = 0; i < 5; i++) push(K_RPT, t + 5 + RD + i * RP, 1, 1'b1);
    wait_cyc(t + 6);
    check("hold_pressed", int'(pressed), 1);
    wait_cyc(t + 25);
    btn_n = 1'b1;
    push(K_REL, t + 31, 1, 1'b0);
    wait_cyc(t + 33);
    check("after_release_pressed", int'(pressed), 0);

    // Two-cycle release glitch while held: repeat counter freezes, no release strobe.
    t = cyc + 1;
    btn_n = 1'b0;
    push(K_PRESS, t + 5, 2, 1'b1);
    wait_cyc(t + 6);
    btn_n = 1'b1;
    wait_cyc(t + 8);
    btn_n = 1'b0;
    wait_cyc(t + 10);
    check("glitch_pressed_held", int'(pressed), 1);
    push(K_RPT, t + 16, 2, 1'b1);
    wait_cyc(t + 16);
    btn_n = 1'b1;
    push(K_REL, t + 22, 2, 1'b0);
    wait_cyc(t + 24);

    // Wrap: 254 more presses bring the count to 256 -> 0.
    for (int k = 3; k <= 256; k++) clean_press(k);
    wait_cyc(cyc + 2);
    check("wrap_count", int'(press_count), 0);

    // Reset while held: everything clears, then the held button is re-debounced.
    t = cyc + 1;
    btn_n = 1'b0;
    push(K_PRESS, t + 5, 1, 1'b1);
    wait_cyc(t + 6);
    reset = 1'b1;
    wait_cyc(t + 8);
    check("midrst_pressed", int'(pressed), 0);
    check("midrst_count", int'(press_count), 0);
    check("midrst_pulses", int'({repeat_pulse, release_pulse, press_pulse}), 0);
    wait_cyc(t + 9);
    reset = 1'b0;
    push(K_PRESS, t + 15, 1, 1'b1);
    wait_cyc(t + 16);
    check("rerun_pressed", int'(pressed), 1);
    check("rerun_count", int'(press_count), 1);
    btn_n = 1'b1;
    push(K_REL, t + 22, 1, 1'b0);
    wait_cyc(t + 30);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
